// File: rtl/psl_resp_monitor.sv
// psl_resp_monitor: runtime checker for the bounded-response property
// "every req is answered by an ack within 1..MAXLAT cycles" on NCH independent
// channels, plus a per-channel "never" condition. Failures are reported as
// registered one-cycle pulses, sticky flags, a saturating count of failing
// cycles and a capture of the first failure (channel and kind).
module psl_resp_monitor #(
  parameter int NCH    = 4,
  parameter int MAXLAT = 8,
  parameter int MAXOUT = 4,
  parameter int ERRW   = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  en_i,
  input  logic                                  clear_i,
  input  logic [NCH-1:0]                        req_i,
  input  logic [NCH-1:0]                        ack_i,
  input  logic [NCH-1:0]                        never_i,
  output logic [NCH-1:0]                        fail_o,
  output logic [NCH-1:0]                        sticky_o,
  output logic [ERRW-1:0]                       err_cnt_o,
  output logic                                  first_valid_o,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] first_ch_o,
  output logic [1:0]                            first_kind_o
);

  // Timestamp width leaves headroom so ages up to MAXLAT never alias on wrap.
  localparam int TSW  = $clog2(MAXLAT) + 2;
  localparam int IDXW = $clog2(MAXOUT);
  localparam int OCW  = IDXW + 1;
  localparam int CHW  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] KIND_TIMEOUT  = 2'd0;
  localparam logic [1:0] KIND_SPURIOUS = 2'd1;
  localparam logic [1:0] KIND_OVERFLOW = 2'd2;
  localparam logic [1:0] KIND_NEVER    = 2'd3;

  logic [TSW-1:0]  r_now;
  logic [TSW-1:0]  r_ts   [NCH][MAXOUT];
  logic [IDXW-1:0] r_head [NCH];
  logic [OCW-1:0]  r_occ  [NCH];
  logic [NCH-1:0]  r_fail;
  logic [NCH-1:0]  r_sticky;
  logic [ERRW-1:0] r_err_cnt;
  logic            r_first_valid;
  logic [CHW-1:0]  r_first_ch;
  logic [1:0]      r_first_kind;

  logic [TSW-1:0]  w_age      [NCH];
  logic [OCW-1:0]  w_occ_after[NCH];
  logic [IDXW-1:0] w_tail     [NCH];
  logic [1:0]      w_kind     [NCH];
  logic [NCH-1:0]  w_tmo, w_spur, w_ovf, w_nev, w_pop, w_push, w_fail;
  logic            w_found;
  logic [CHW-1:0]  w_first_ch;
  logic [1:0]      w_first_kind;

  // Per-channel pop/push decisions and failure classification for this cycle.
  always_comb begin
    // NOTE: every always_comb output gets a default before any conditional
    // assignment, so no path can leave it unassigned and infer a latch.
    w_tmo   = '0;
    w_spur  = '0;
    w_ovf   = '0;
    w_nev   = '0;
    w_pop   = '0;
    w_push  = '0;
    w_fail  = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      w_age[ch]       = r_now - r_ts[ch][r_head[ch]];
      w_tail[ch]      = r_head[ch] + r_occ[ch][IDXW-1:0];
      w_spur[ch]      = en_i & ack_i[ch] & (r_occ[ch] == '0);
      w_tmo[ch]       = en_i & ~ack_i[ch] & (r_occ[ch] != '0) &
                        (w_age[ch] == TSW'(MAXLAT));
      w_pop[ch]       = (en_i & ack_i[ch] & (r_occ[ch] != '0)) | w_tmo[ch];
      w_occ_after[ch] = r_occ[ch] - OCW'(w_pop[ch]);
      w_ovf[ch]       = en_i & req_i[ch] & (w_occ_after[ch] == OCW'(MAXOUT));
      w_push[ch]      = en_i & req_i[ch] & (w_occ_after[ch] != OCW'(MAXOUT));
      w_nev[ch]       = en_i & never_i[ch];
      w_fail[ch]      = w_tmo[ch] | w_spur[ch] | w_ovf[ch] | w_nev[ch];
      if (w_tmo[ch])       w_kind[ch] = KIND_TIMEOUT;
      else if (w_spur[ch]) w_kind[ch] = KIND_SPURIOUS;
      else if (w_ovf[ch])  w_kind[ch] = KIND_OVERFLOW;
      else                 w_kind[ch] = KIND_NEVER;
    end
  end

  // Lowest failing channel and its highest-priority kind, for first capture.
  always_comb begin
    w_found      = 1'b0;
    w_first_ch   = '0;
    w_first_kind = KIND_TIMEOUT;
    for (int ch = 0; ch < NCH; ch++) begin
      if (w_fail[ch] && !w_found) begin
        w_found      = 1'b1;
        w_first_ch   = CHW'(ch);
        w_first_kind = w_kind[ch];
      end
    end
  end

  // Queue bookkeeping: head pointer and occupancy; disabling flushes all queues.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples values from before the edge regardless of block order.
    if (!rst_n) begin
      for (int ch = 0; ch < NCH; ch++) begin
        r_head[ch] <= '0;
        r_occ[ch]  <= '0;
      end
    end else begin
      for (int ch = 0; ch < NCH; ch++) begin
        if (!en_i) begin
          r_head[ch] <= '0;
          r_occ[ch]  <= '0;
        end else begin
          r_head[ch] <= r_head[ch] + IDXW'(w_pop[ch]);
          r_occ[ch]  <= w_occ_after[ch] + OCW'(w_push[ch]);
        end
      end
    end
  end

  // Timestamp storage: write the current time into the tail slot on a push.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; a slot is only read while the
    // occupancy count says it holds a pushed entry, so its content is defined.
    for (int ch = 0; ch < NCH; ch++) begin
      if (w_push[ch]) r_ts[ch][w_tail[ch]] <= r_now;
    end
  end

  // Timestamp, failure pulse, sticky flags, saturating count and first capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_now         <= '0;
      r_fail        <= '0;
      r_sticky      <= '0;
      r_err_cnt     <= '0;
      r_first_valid <= 1'b0;
      r_first_ch    <= '0;
      r_first_kind  <= '0;
    end else begin
      r_now  <= r_now + 1'b1;
      r_fail <= w_fail;
      if (clear_i) begin
        r_sticky      <= '0;
        r_err_cnt     <= '0;
        r_first_valid <= 1'b0;
        r_first_ch    <= '0;
        r_first_kind  <= '0;
      end else begin
        r_sticky <= r_sticky | w_fail;
        if (w_found && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
        if (w_found && !r_first_valid) begin
          r_first_valid <= 1'b1;
          r_first_ch    <= w_first_ch;
          r_first_kind  <= w_first_kind;
        end
      end
    end
  end

  assign fail_o        = r_fail;
  assign sticky_o      = r_sticky;
  assign err_cnt_o     = r_err_cnt;
  assign first_valid_o = r_first_valid;
  assign first_ch_o    = r_first_ch;
  assign first_kind_o  = r_first_kind;

endmodule

// File: tb/tb_psl_resp_monitor.sv
// Directed testbench for psl_resp_monitor (NCH=4, MAXLAT=8, MAXOUT=4), with a
// second instance using ERRW=2 that shares the stimulus for saturation checks.
module tb_psl_resp_monitor;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       en_i    = 1'b0;
  logic       clear_i = 1'b0;
  logic [3:0] req_i   = '0;
  logic [3:0] ack_i   = '0;
  logic [3:0] never_i = '0;

  logic [3:0]  fail_o, sticky_o;
  logic [15:0] err_cnt_o;
  logic        first_valid_o;
  logic [1:0]  first_ch_o, first_kind_o;

  logic [3:0]  s_fail, s_sticky;
  logic [1:0]  s_err;
  logic        s_fv;
  logic [1:0]  s_fch, s_fkind;

  logic [3:0]  acc;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  psl_resp_monitor #(.NCH(4), .MAXLAT(8), .MAXOUT(4), .ERRW(16)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .clear_i(clear_i),
    .req_i(req_i), .ack_i(ack_i), .never_i(never_i),
    .fail_o(fail_o), .sticky_o(sticky_o), .err_cnt_o(err_cnt_o),
    .first_valid_o(first_valid_o), .first_ch_o(first_ch_o),
    .first_kind_o(first_kind_o)
  );

  psl_resp_monitor #(.NCH(4), .MAXLAT(8), .MAXOUT(4), .ERRW(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .clear_i(clear_i),
    .req_i(req_i), .ack_i(ack_i), .never_i(never_i),
    .fail_o(s_fail), .sticky_o(s_sticky), .err_cnt_o(s_err),
    .first_valid_o(s_fv), .first_ch_o(s_fch), .first_kind_o(s_fkind)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n clock edges; outputs are sampled 1 time unit after each edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick(1);
    clear_i = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(2);
    check("rst_fail",   32'(fail_o), 32'h0);
    check("rst_sticky", 32'(sticky_o), 32'h0);
    check("rst_err",    32'(err_cnt_o), 32'h0);
    check("rst_fv",     32'(first_valid_o), 32'h0);
    check("rst_s_err",  32'(s_err), 32'h0);
    rst_n = 1'b1;
    en_i  = 1'b1;
    tick(2);

    // Ack at exactly MAXLAT cycles passes
    req_i = 4'b0001; tick(1); req_i = '0;
    tick(7);
    ack_i = 4'b0001; tick(1); ack_i = '0;
    check("t1_fail", 32'(fail_o), 32'h0);
    tick(1);
    check("t1_err",    32'(err_cnt_o), 32'h0);
    check("t1_sticky", 32'(sticky_o), 32'h0);

    // Timeout on ch1
    req_i = 4'b0010; tick(1); req_i = '0;
    tick(7);
    check("t2_no_early", 32'(fail_o), 32'h0);
    tick(1);
    check("t2_fail",   32'(fail_o), 32'h2);
    check("t2_sticky", 32'(sticky_o), 32'h2);
    check("t2_err",    32'(err_cnt_o), 32'h1);
    check("t2_fv",     32'(first_valid_o), 32'h1);
    check("t2_fch",    32'(first_ch_o), 32'h1);
    check("t2_fkind",  32'(first_kind_o), 32'h0);
    tick(1);
    check("t2_pulse_end", 32'(fail_o), 32'h0);

    // Spurious ack with same-cycle req; queued req answered 3 cycles later
    req_i = 4'b0100; ack_i = 4'b0100; tick(1); req_i = '0; ack_i = '0;
    check("t3_fail",  32'(fail_o), 32'h4);
    check("t3_err",   32'(err_cnt_o), 32'h2);
    check("t3_fch",   32'(first_ch_o), 32'h1);
    check("t3_fkind", 32'(first_kind_o), 32'h0);
    tick(2);
    ack_i = 4'b0100; tick(1); ack_i = '0;
    check("t3_ack_pass", 32'(fail_o), 32'h0);
    check("t3_err2",     32'(err_cnt_o), 32'h2);

    // Overflow on ch3, then four timeouts
    do_clear();
    check("t4_clr_sticky", 32'(sticky_o), 32'h0);
    check("t4_clr_err",    32'(err_cnt_o), 32'h0);
    check("t4_clr_fv",     32'(first_valid_o), 32'h0);
    req_i = 4'b1000; tick(4);
    tick(1); req_i = '0;
    check("t4_ovf_fail",  32'(fail_o), 32'h8);
    check("t4_ovf_err",   32'(err_cnt_o), 32'h1);
    check("t4_ovf_fch",   32'(first_ch_o), 32'h3);
    check("t4_ovf_fkind", 32'(first_kind_o), 32'h2);
    tick(3);
    check("t4_gap", 32'(fail_o), 32'h0);
    tick(1);
    check("t4_tmo1_fail", 32'(fail_o), 32'h8);
    check("t4_tmo1_err",  32'(err_cnt_o), 32'h2);
    tick(3);
    check("t4_tmo4_fail", 32'(fail_o), 32'h8);
    check("t4_tmo4_err",  32'(err_cnt_o), 32'h5);
    tick(1);
    check("t4_quiet", 32'(fail_o), 32'h0);

    // never on ch0 coincides with timeout on ch2
    do_clear();
    req_i = 4'b0100; tick(1); req_i = '0;
    tick(7);
    never_i = 4'b0001; tick(1); never_i = '0;
    check("t5_fail",   32'(fail_o), 32'h5);
    check("t5_sticky", 32'(sticky_o), 32'h5);
    check("t5_err",    32'(err_cnt_o), 32'h1);
    check("t5_fch",    32'(first_ch_o), 32'h0);
    check("t5_fkind",  32'(first_kind_o), 32'h3);

    // Disable: no new pulses, records hold, queues flushed
    do_clear();
    never_i = 4'b1000; tick(1);
    check("t6_fail", 32'(fail_o), 32'h8);
    en_i = 1'b0; tick(1); never_i = '0;
    check("t6_dis_fail",   32'(fail_o), 32'h0);
    check("t6_dis_sticky", 32'(sticky_o), 32'h8);
    check("t6_dis_err",    32'(err_cnt_o), 32'h1);
    en_i = 1'b1;
    req_i = 4'b0010; tick(1); req_i = '0;
    tick(2);
    en_i = 1'b0; tick(1); en_i = 1'b1;
    acc = '0;
    repeat (10) begin
      tick(1);
      acc = acc | fail_o;
    end
    check("t6_flush_nofail", 32'(acc), 32'h0);
    check("t6_flush_err",    32'(err_cnt_o), 32'h1);

    // Clear wins over a same-cycle failure, but the pulse still appears
    clear_i = 1'b1; never_i = 4'b0010; tick(1); clear_i = 1'b0; never_i = '0;
    check("t7_fail",   32'(fail_o), 32'h2);
    check("t7_sticky", 32'(sticky_o), 32'h0);
    check("t7_err",    32'(err_cnt_o), 32'h0);
    check("t7_fv",     32'(first_valid_o), 32'h0);

    // Saturation with ERRW=2
    do_clear();
    check("t8_s_err0", 32'(s_err), 32'h0);
    never_i = 4'b0001; tick(5); never_i = '0;
    check("t8_err",      32'(err_cnt_o), 32'h5);
    check("t8_s_sat",    32'(s_err), 32'h3);
    check("t8_s_sticky", 32'(s_sticky), 32'h1);
    do_clear();
    check("t8_s_clr_err",    32'(s_err), 32'h0);
    check("t8_s_clr_sticky", 32'(s_sticky), 32'h0);
    check("t8_s_clr_fv",     32'(s_fv), 32'h0);

    // Asynchronous reset mid-queue with a pulse in flight
    never_i = 4'b0100; req_i = 4'b0010; tick(1); never_i = '0; req_i = '0;
    check("t9_pre_fail", 32'(fail_o), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("t9_rst_fail",   32'(fail_o), 32'h0);
    check("t9_rst_sticky", 32'(sticky_o), 32'h0);
    check("t9_rst_err",    32'(err_cnt_o), 32'h0);
    check("t9_rst_fv",     32'(first_valid_o), 32'h0);
    #2 rst_n = 1'b1;
    acc = '0;
    repeat (12) begin
      tick(1);
      acc = acc | fail_o;
    end
    check("t9_no_timeout", 32'(acc), 32'h0);
    check("t9_err",        32'(err_cnt_o), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
